// File: rtl/e3_mux_7seg_driver.sv
// Time-multiplexed 7-segment driver for an N_DIG-digit Excess-3 number.
// Double-buffered input, leading-zero blanking and sticky invalid-code flag.
module e3_mux_7seg_driver #(
    parameter int N_DIG    = 4,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [4*N_DIG-1:0] e3_number,
    input  logic               blank_lz,
    input  logic               err_clr,
    output logic [7:0]         seg,
    output logic [N_DIG-1:0]   an,
    output logic               frame_done,
    output logic               err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [PW-1:0]      P_LAST    = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]      I_LAST    = IW'(N_DIG - 1);
    localparam logic [4*N_DIG-1:0] ALL_ZEROS = {N_DIG{4'h3}};

    logic [PW-1:0]      p_q, p_d;
    logic [IW-1:0]      i_q, i_d;
    logic [4*N_DIG-1:0] stage_q, stage_d;
    logic [4*N_DIG-1:0] act_q, act_d;
    logic [7:0]         seg_q, seg_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic               fd_q, fd_d;
    logic               err_q, err_d;

    logic               boundary;
    logic [3:0]         cur_code;
    logic               cur_blank;
    logic               cur_invalid;
    logic [N_DIG-1:0]   lz;

    function automatic logic [7:0] e3_pattern(input logic [3:0] code);
        case (code)
            4'd3:    e3_pattern = 8'h3F;
            4'd4:    e3_pattern = 8'h06;
            4'd5:    e3_pattern = 8'h5B;
            4'd6:    e3_pattern = 8'h4F;
            4'd7:    e3_pattern = 8'h66;
            4'd8:    e3_pattern = 8'h6D;
            4'd9:    e3_pattern = 8'h7D;
            4'd10:   e3_pattern = 8'h07;
            4'd11:   e3_pattern = 8'h7F;
            4'd12:   e3_pattern = 8'h6F;
            default: e3_pattern = 8'h40;
        endcase
    endfunction

    assign boundary = en && (p_q == P_LAST) && (i_q == I_LAST);

    always_comb begin
        p_d = p_q;
        i_d = i_q;
        if (en) begin
            if (p_q == P_LAST) begin
                p_d = '0;
                i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
            end else begin
                p_d = p_q + 1'b1;
            end
        end
    end

    // A load in the boundary cycle bypasses staging so no stale frame is shown.
    always_comb begin
        stage_d = load ? e3_number : stage_q;
        act_d   = act_q;
        if (boundary) begin
            act_d = load ? e3_number : stage_q;
        end
    end

    // Zero-run scanned from the most significant digit; digit 0 is never part of it.
    always_comb begin
        logic        run;
        int unsigned k;
        run       = 1'b1;
        k         = 0;
        lz        = '0;
        cur_code  = 4'h3;
        cur_blank = 1'b0;
        an_d      = '0;
        for (int unsigned j = 0; j < N_DIG; j++) begin
            k     = N_DIG - 1 - j;
            run   = run && (act_q[4*k +: 4] == 4'h3);
            lz[k] = run && (k != 0);
        end
        for (int unsigned m = 0; m < N_DIG; m++) begin
            an_d[m] = en && (i_q == IW'(m));
            if (i_q == IW'(m)) begin
                cur_code  = act_q[4*m +: 4];
                cur_blank = blank_lz && lz[m];
            end
        end
    end

    assign cur_invalid = (cur_code < 4'd3) || (cur_code > 4'd12);

    always_comb begin
        seg_d = '0;
        if (en && !cur_blank) begin
            seg_d = e3_pattern(cur_code);
        end
        fd_d  = boundary;
        err_d = err_q;
        if (en && !cur_blank && cur_invalid) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            i_q     <= '0;
            stage_q <= ALL_ZEROS;
            act_q   <= ALL_ZEROS;
            seg_q   <= '0;
            an_q    <= '0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            i_q     <= i_d;
            stage_q <= stage_d;
            act_q   <= act_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_e3_mux_7seg_driver.sv
// Directed bench for e3_mux_7seg_driver (N_DIG=2, PRESCALE=2) with a
// cycle-level reference model feeding a scoreboard queue.
module tb_e3_mux_7seg_driver;

    localparam int ND = 2;
    localparam int PS = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [7:0]  e3_number;
    logic        blank_lz;
    logic        err_clr;
    logic [7:0]  seg;
    logic [1:0]  an;
    logic        frame_done;
    logic        err;

    e3_mux_7seg_driver #(.N_DIG(ND), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .e3_number  (e3_number),
        .blank_lz   (blank_lz),
        .err_clr    (err_clr),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] seg;
        logic [1:0] an;
        logic       fd;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int         mp;
    int         mi;
    logic [7:0] mstage;
    logic [7:0] mact;
    logic       merr;

    function automatic logic invalid(input logic [3:0] c);
        return (c < 4'd3) || (c > 4'd12);
    endfunction

    function automatic logic [7:0] pat(input logic [3:0] c);
        logic [7:0] tbl [10];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        if (invalid(c)) return 8'h40;
        return tbl[c - 4'd3];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mp     = 0;
        mi     = 0;
        mstage = 8'h33;
        mact   = 8'h33;
        merr   = 1'b0;
    endtask

    task automatic step(input string tag);
        exp_t       e;
        logic [3:0] code;
        logic       blk;
        logic       bnd;
        code  = (mi == 0) ? mact[3:0] : mact[7:4];
        blk   = blank_lz && (mi == 1) && (code == 4'h3);
        bnd   = en && (mp == PS - 1) && (mi == ND - 1);
        e.seg = en ? (blk ? 8'h00 : pat(code)) : 8'h00;
        e.an  = en ? ((mi == 0) ? 2'b01 : 2'b10) : 2'b00;
        e.fd  = bnd;
        e.err = (en && !blk && invalid(code)) ? 1'b1 : (err_clr ? 1'b0 : merr);
        sb.push_back(e);
        if (bnd) mact = load ? e3_number : mstage;
        if (load) mstage = e3_number;
        merr = e.err;
        if (en) begin
            if (mp == PS - 1) begin
                mp = 0;
                mi = (mi == ND - 1) ? 0 : mi + 1;
            end else begin
                mp++;
            end
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".seg"}, seg, e.seg);
        chk({tag, ".an"}, {6'b0, an}, {6'b0, e.an});
        chk({tag, ".fd"}, {7'b0, frame_done}, {7'b0, e.fd});
        chk({tag, ".err"}, {7'b0, err}, {7'b0, e.err});
    endtask

    initial begin
        logic [1:0] an_seq [8];
        logic       fd_seq [8];
        an_seq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        fd_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        e3_number = 8'h00;
        blank_lz  = 1'b0;
        err_clr   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset.seg", seg, 8'h00);
        chk("reset.an", {6'b0, an}, 8'h00);
        chk("reset.fd", {7'b0, frame_done}, 8'h00);
        chk("reset.err", {7'b0, err}, 8'h00);
        rst = 1'b0;

        // Free-running scan of the reset value
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step("scan");
            chk("scan.an_seq", {6'b0, an}, {6'b0, an_seq[c]});
            chk("scan.fd_seq", {7'b0, frame_done}, {7'b0, fd_seq[c]});
            chk("scan.seg_zero", seg, 8'h3F);
        end

        en = 1'b0;
        step("hold");
        step("hold");
        en = 1'b1;

        // Mid-frame load only takes effect at the next boundary
        load = 1'b1; e3_number = 8'h47;
        step("ld47");
        load = 1'b0; e3_number = 8'h00;
        step("ld47");
        step("ld47");
        chk("ld47.stale", seg, 8'h3F);
        step("ld47");
        step("f47");
        chk("f47.d0", seg, 8'h66);
        step("f47");
        step("f47");
        chk("f47.d1", seg, 8'h06);

        // Load in the boundary cycle shows up in the very next frame
        load = 1'b1; e3_number = 8'h58;
        step("ld58");
        chk("ld58.old", seg, 8'h06);
        load = 1'b0; e3_number = 8'h00;
        step("f58");
        chk("f58.d0", seg, 8'h6D);
        step("f58");
        step("f58");
        chk("f58.d1", seg, 8'h5B);
        load = 1'b1; e3_number = 8'h37;
        step("ld37");
        load = 1'b0; e3_number = 8'h00;

        // Leading-zero blanking
        blank_lz = 1'b1;
        step("lz");
        chk("lz.d0", seg, 8'h66);
        step("lz");
        step("lz");
        chk("lz.d1_blank", seg, 8'h00);
        step("lz");
        blank_lz = 1'b0;
        step("nolz");
        step("nolz");
        step("nolz");
        chk("nolz.d1", seg, 8'h3F);
        load = 1'b1; e3_number = 8'hF3; blank_lz = 1'b1;
        step("ldF3");
        load = 1'b0; e3_number = 8'h00;

        // Invalid code, sticky error, clear and set-wins
        step("fF3");
        chk("fF3.d0", seg, 8'h3F);
        step("fF3");
        step("fF3");
        chk("fF3.dash", seg, 8'h40);
        chk("fF3.err", {7'b0, err}, 8'h01);
        step("fF3");
        err_clr = 1'b1;
        step("clr");
        chk("clr.err", {7'b0, err}, 8'h00);
        err_clr = 1'b0;
        step("clr");
        err_clr = 1'b1;
        step("setwins");
        chk("setwins.err", {7'b0, err}, 8'h01);
        err_clr = 1'b0;
        step("setwins");

        // Park mid-scan at i=1, p=1 with a pending staged value
        load = 1'b1; e3_number = 8'h99;
        step("park");
        load = 1'b0; e3_number = 8'h00;
        step("park");
        step("park");

        rst = 1'b1;
        #1;
        chk("arst.seg", seg, 8'h00);
        chk("arst.an", {6'b0, an}, 8'h00);
        chk("arst.fd", {7'b0, frame_done}, 8'h00);
        chk("arst.err", {7'b0, err}, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("post");
        chk("post.seg", seg, 8'h3F);
        chk("post.an", {6'b0, an}, 8'h01);
        step("post");
        step("post");
        chk("post.an1", {6'b0, an}, 8'h02);
        step("post");
        step("post");
        chk("post.lost", seg, 8'h3F);
        step("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
